hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline.
- Generalised to N memory stages.
- Tracks in-flight destination registers in its own shadow pipe.
- Drives PC/IF-ID stall, ID/EX bubble, IF/ID flush, and registered EX-stage forwarding selects.
- Sits beside Instruction_Decode; replaces the tied-off stall inputs in the processor top.

Parameters:
- REG_ADDR_W, 5: register-address width; register 0 is hard-wired zero.
- MEM_STAGES, 1: number of memory pipeline stages, legal range 1..4.
  - D = MEM_STAGES+2 shadow entries: entry 0 = EX, entries 1..MEM_STAGES = MEM, entry D-1 = WB.
  - FWD_W = clog2(D).

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ID_Valid  in  1  ID holds a real instruction.
- Rs_ID  in  REG_ADDR_W  source A.
- Rt_ID  in  REG_ADDR_W  source B.
- Use_Rs_ID  in  1  source A is read.
- Use_Rt_ID  in  1  source B is read.
- Dest_ID  in  REG_ADDR_W  selected destination.
- RegWrite_ID  in  1  ID instruction writes a register.
- MemRead_ID  in  1  ID instruction is a load.
- Is_Branch_ID  in  1  branch/compare resolved in ID.
- Branch_Taken_ID  in  1  branch taken.
- Mem_Busy  in  1  data memory not ready; freeze.
- Stall_PC  out  1  hold PC.
- Stall_ID  out  1  hold IF/ID.
- Bubble_ID_EX  out  1  insert NOP into ID/EX.
- Flush_IF_ID  out  1  squash IF/ID.
- Freeze  out  1  hold all pipeline registers.
- Fwd_A_EX  out  FWD_W  EX operand-A source: 0 = register file, k = shadow entry k.
- Fwd_B_EX  out  FWD_W  same, for operand B.

Behaviour:
- Shadow entry fields: {valid, dest, regwrite, is_load}.
- A source s "matches" entry k when all hold: use bit set, s != 0, entry valid & regwrite, dest == s. The nearest match (smallest k) wins.
- Load-use hazard (lu): nearest match is a load with k < MEM_STAGES. Load data is forwardable only from WB; ALU results are forwardable from any entry >= 1.
- Branch hazard (bh): Is_Branch_ID with any match at k < D-1. ID has no forwarding.
- A match at k = D-1 is not a hazard. The register file is required to be write-through.
- haz = ID_Valid & (lu | bh).
- Combinational outputs:
  - Freeze = Mem_Busy.
  - Stall_PC = Stall_ID = Mem_Busy | haz.
  - Bubble_ID_EX = haz & !Mem_Busy.
  - Flush_IF_ID = Branch_Taken_ID & ID_Valid & !haz & !Mem_Busy.
- Sequential update on the clock edge:
  - Mem_Busy: hold all entries and Fwd_*.
  - Else if haz: shift entries up (k -> k+1; entry D-1 drops); entry 0 <= invalid; Fwd_* <= 0.
  - Else: shift up; entry 0 <= {ID_Valid, Dest_ID, RegWrite_ID, MemRead_ID}.
    - Fwd_A_EX <= (nearest match k for Rs_ID) + 1, else 0. Same rule for Fwd_B_EX with Rt_ID.
    - The +1 accounts for the producer advancing one entry alongside the consumer.
    - A result > D-1 cannot occur once hazards are honoured.
- Latency:
  - Stall/bubble/flush: 0 cycles (combinational).
  - Fwd selects: valid in the cycle the consumer occupies EX.
- Load-use stall length = MEM_STAGES - k cycles.
- Reset (asynchronous, any time):
  - All entries invalid; Fwd_A_EX = Fwd_B_EX = 0.
  - Combinational outputs then follow inputs. Stall outputs read 0 unless Mem_Busy is set.
- Simultaneous events:
  - Mem_Busy dominates everything.
  - A hazard suppresses the flush; the branch resolves after the stall.
  - Rs == Rt: both selects get the same index.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs Stall_Cnt (32 bit) and Flush_Cnt (32 bit).
  - Stall_Cnt increments on each non-frozen cycle with haz.
  - Flush_Cnt increments on each cycle with Flush_IF_ID.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- MEM_STAGES=1, lw $8 followed by add $9,$8,$8:
  - One cycle with Stall_PC=Stall_ID=Bubble_ID_EX=1.
  - Add enters EX with Fwd_A_EX=Fwd_B_EX=2.
- MEM_STAGES=1, add $8 followed by sub $10,$8,$3:
  - No stall.
  - Fwd_A_EX=1 and Fwd_B_EX=0 when sub is in EX.
- MEM_STAGES=3, lw $5 followed by or using $5: exactly 3 stall cycles, then Fwd_A_EX=4.
- beq $4,$0 directly after add $4 with MEM_STAGES=1:
  - 2 stall cycles.
  - Then, with Branch_Taken_ID=1: Flush_IF_ID=1 for one cycle.
  - Instructions writing $0 never stall.
- Mem_Busy held 3 cycles during a load-use stall:
  - Freeze=1; entries and Fwd_* unchanged; Bubble_ID_EX=0.
  - After release, the remaining stall completes normally.
- Reset_n asserted mid-stall: entries cleared immediately; stall outputs drop to 0 with Mem_Busy=0.
  - With HAZARD_PERF_CNT_EN defined: counters read 0 after reset, and 2 after two stalled cycles.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Hazard-detection and EX-stage forwarding controller for the MIPS pipeline,
//   generalised to MEM_STAGES memory stages. A private shadow pipe of
//   D = MEM_STAGES+2 entries tracks in-flight destinations:
//   entry 0 = EX, entries 1..MEM_STAGES = MEM, entry D-1 = WB.
//
//   Ports
//     Clock, Reset_n            rising-edge clock, async active-low reset
//     ID_Valid                  ID holds a real instruction
//     Rs_ID, Rt_ID              source register addresses
//     Use_Rs_ID, Use_Rt_ID      source is actually read
//     Dest_ID, RegWrite_ID      destination and its write enable
//     MemRead_ID                ID instruction is a load
//     Is_Branch_ID              branch/compare resolved in ID
//     Branch_Taken_ID           branch taken
//     Mem_Busy                  data memory not ready (freeze everything)
//     Stall_PC, Stall_ID        hold PC and IF/ID
//     Bubble_ID_EX              insert NOP into ID/EX
//     Flush_IF_ID               squash IF/ID
//     Freeze                    hold all pipeline registers
//     Fwd_A_EX, Fwd_B_EX        registered EX operand source:
//                               0 = register file, k = shadow entry k
//
//   Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters
//   Stall_Cnt (non-frozen hazard cycles) and Flush_Cnt (flush cycles).
module hazard_fwd_ctrl #(
  parameter  int REG_ADDR_W = 5,
  parameter  int MEM_STAGES = 1,
  localparam int D          = MEM_STAGES + 2,
  localparam int FWD_W      = $clog2(D)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Use_Rs_ID,
  input  logic                  Use_Rt_ID,
  input  logic [REG_ADDR_W-1:0] Dest_ID,
  input  logic                  RegWrite_ID,
  input  logic                  MemRead_ID,
  input  logic                  Is_Branch_ID,
  input  logic                  Branch_Taken_ID,
  input  logic                  Mem_Busy,
  output logic                  Stall_PC,
  output logic                  Stall_ID,
  output logic                  Bubble_ID_EX,
  output logic                  Flush_IF_ID,
  output logic                  Freeze,
  output logic [FWD_W-1:0]      Fwd_A_EX,
  output logic [FWD_W-1:0]      Fwd_B_EX
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           Stall_Cnt,
  output logic [31:0]           Flush_Cnt
`endif
);

  logic [D-1:0]                 r_valid;
  logic [D-1:0]                 r_rw;
  logic [D-1:0]                 r_ld;
  logic [D-1:0][REG_ADDR_W-1:0] r_dest;
  logic [FWD_W-1:0]             r_fwd_a;
  logic [FWD_W-1:0]             r_fwd_b;

  logic             w_lu_a, w_lu_b;
  logic             w_bh_a, w_bh_b;
  logic [FWD_W-1:0] w_fwd_a, w_fwd_b;
  logic             w_haz;

  // Scan from WB down to EX so the nearest (smallest k) match is written last.
  // Loop index j equals k+1, which is exactly the forwarding select the
  // consumer needs once producer and consumer have both advanced one entry.
  // A match in WB yields 0: the write-through register file supplies it.
  function automatic logic [FWD_W+1:0] scan_src(
    input logic                  use_s,
    input logic [REG_ADDR_W-1:0] s
  );
    logic             lu;
    logic             bh;
    logic [FWD_W-1:0] fwd;
    lu  = 1'b0;
    bh  = 1'b0;
    fwd = '0;
    for (int unsigned j = D; j > 0; j--) begin
      if (use_s && (s != '0) && r_valid[j-1] && r_rw[j-1] && (r_dest[j-1] == s)) begin
        lu  = r_ld[j-1] && (j <= MEM_STAGES);
        bh  = (j < D);
        fwd = (j < D) ? FWD_W'(j) : '0;
      end
    end
    return {lu, bh, fwd};
  endfunction

  always_comb begin
    {w_lu_a, w_bh_a, w_fwd_a} = scan_src(Use_Rs_ID, Rs_ID);
    {w_lu_b, w_bh_b, w_fwd_b} = scan_src(Use_Rt_ID, Rt_ID);
    w_haz = ID_Valid & (w_lu_a | w_lu_b | (Is_Branch_ID & (w_bh_a | w_bh_b)));
  end

  assign Freeze       = Mem_Busy;
  assign Stall_PC     = Mem_Busy | w_haz;
  assign Stall_ID     = Mem_Busy | w_haz;
  assign Bubble_ID_EX = w_haz & ~Mem_Busy;
  assign Flush_IF_ID  = Branch_Taken_ID & ID_Valid & ~w_haz & ~Mem_Busy;
  assign Fwd_A_EX     = r_fwd_a;
  assign Fwd_B_EX     = r_fwd_b;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid <= '0;
      r_rw    <= '0;
      r_ld    <= '0;
      r_dest  <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (!Mem_Busy) begin
      r_valid <= {r_valid[D-2:0], ID_Valid & ~w_haz};
      r_rw    <= {r_rw[D-2:0],    RegWrite_ID};
      r_ld    <= {r_ld[D-2:0],    MemRead_ID};
      r_dest  <= {r_dest[D-2:0],  Dest_ID};
      r_fwd_a <= w_haz ? '0 : w_fwd_a;
      r_fwd_b <= w_haz ? '0 : w_fwd_b;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_haz && !Mem_Busy) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (Flush_IF_ID)        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two instances (MEM_STAGES=1 and 3) share the
// same stimulus. The reference model keeps a list of in-flight writers tagged
// by age (cycles since leaving ID) rather than a shift register.
module tb_hazard_fwd_ctrl;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ID_Valid, Use_Rs_ID, Use_Rt_ID, RegWrite_ID, MemRead_ID;
  logic       Is_Branch_ID, Branch_Taken_ID, Mem_Busy;
  logic [4:0] Rs_ID, Rt_ID, Dest_ID;

  logic       spc1, sid1, bub1, fl1, frz1;
  logic [1:0] fa1, fb1;
  logic       spc3, sid3, bub3, fl3, frz3;
  logic [2:0] fa3, fb3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  always #5 Clock = ~Clock;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MEM_STAGES(1)) u_ms1 (
    .Clock(Clock), .Reset_n(Reset_n), .ID_Valid(ID_Valid),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Use_Rs_ID(Use_Rs_ID), .Use_Rt_ID(Use_Rt_ID),
    .Dest_ID(Dest_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .Is_Branch_ID(Is_Branch_ID), .Branch_Taken_ID(Branch_Taken_ID), .Mem_Busy(Mem_Busy),
    .Stall_PC(spc1), .Stall_ID(sid1), .Bubble_ID_EX(bub1), .Flush_IF_ID(fl1),
    .Freeze(frz1), .Fwd_A_EX(fa1), .Fwd_B_EX(fb1)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cnt(sc1), .Flush_Cnt(fc1)
`endif
  );

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MEM_STAGES(3)) u_ms3 (
    .Clock(Clock), .Reset_n(Reset_n), .ID_Valid(ID_Valid),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Use_Rs_ID(Use_Rs_ID), .Use_Rt_ID(Use_Rt_ID),
    .Dest_ID(Dest_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .Is_Branch_ID(Is_Branch_ID), .Branch_Taken_ID(Branch_Taken_ID), .Mem_Busy(Mem_Busy),
    .Stall_PC(spc3), .Stall_ID(sid3), .Bubble_ID_EX(bub3), .Flush_IF_ID(fl3),
    .Freeze(frz3), .Fwd_A_EX(fa3), .Fwd_B_EX(fb3)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cnt(sc3), .Flush_Cnt(fc3)
`endif
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          live;
    logic [4:0]  d;
    bit          ld;
    int unsigned age;
  } flight_t;

  flight_t     fl [2][8];
  int unsigned ms [2];
  int unsigned m_fa [2], m_fb [2], m_sc [2], m_fc [2];

  function automatic int nearest(input int i, input logic [4:0] s, input bit use_s);
    int best = -1;
    for (int n = 0; n < 8; n++)
      if (fl[i][n].live && use_s && s != 0 && fl[i][n].d == s &&
          (best < 0 || fl[i][n].age < fl[i][best].age))
        best = n;
    return best;
  endfunction

  function automatic bit m_haz(input int i);
    int a = nearest(i, Rs_ID, Use_Rs_ID);
    int b = nearest(i, Rt_ID, Use_Rt_ID);
    int unsigned wb = ms[i] + 1;
    bit lu, bh;
    lu = (a >= 0 && fl[i][a].ld && fl[i][a].age < ms[i]) ||
         (b >= 0 && fl[i][b].ld && fl[i][b].age < ms[i]);
    bh = Is_Branch_ID && ((a >= 0 && fl[i][a].age < wb) || (b >= 0 && fl[i][b].age < wb));
    return ID_Valid && (lu || bh);
  endfunction

  function automatic int unsigned m_fwd(input int i, input logic [4:0] s, input bit use_s);
    int n = nearest(i, s, use_s);
    if (n < 0) return 0;
    if (fl[i][n].age < ms[i] + 1) return fl[i][n].age + 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 8; n++) fl[i][n].live = 0;
      m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_adv(input int i);
    bit h;
    bit placed;
    if (Mem_Busy) return;
    h = m_haz(i);
    if (Branch_Taken_ID && ID_Valid && !h) m_fc[i]++;
    if (h) m_sc[i]++;
    m_fa[i] = h ? 0 : m_fwd(i, Rs_ID, Use_Rs_ID);
    m_fb[i] = h ? 0 : m_fwd(i, Rt_ID, Use_Rt_ID);
    for (int n = 0; n < 8; n++)
      if (fl[i][n].live) begin
        fl[i][n].age++;
        if (fl[i][n].age > ms[i] + 1) fl[i][n].live = 0;
      end
    placed = 0;
    if (!h && ID_Valid && RegWrite_ID)
      for (int n = 0; n < 8; n++)
        if (!placed && !fl[i][n].live) begin
          fl[i][n] = '{live: 1, d: Dest_ID, ld: MemRead_ID, age: 0};
          placed = 1;
        end
  endtask

  task automatic check_inst(input int i, input string nm, input logic spc, input logic sid,
                            input logic bub, input logic flu, input logic frz,
                            input logic [2:0] fa, input logic [2:0] fb);
    bit h = m_haz(i);
    check_eq({nm, ".stall_pc"}, 32'(spc), 32'(Mem_Busy || h));
    check_eq({nm, ".stall_id"}, 32'(sid), 32'(Mem_Busy || h));
    check_eq({nm, ".bubble"},   32'(bub), 32'(h && !Mem_Busy));
    check_eq({nm, ".flush"},    32'(flu), 32'(Branch_Taken_ID && ID_Valid && !h && !Mem_Busy));
    check_eq({nm, ".freeze"},   32'(frz), 32'(Mem_Busy));
    check_eq({nm, ".fwd_a"},    32'(fa),  m_fa[i]);
    check_eq({nm, ".fwd_b"},    32'(fb),  m_fb[i]);
  endtask

  task automatic sample();
    @(negedge Clock);
    check_inst(0, "ms1", spc1, sid1, bub1, fl1, frz1, {1'b0, fa1}, {1'b0, fb1});
    check_inst(1, "ms3", spc3, sid3, bub3, fl3, frz3, fa3, fb3);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("ms1.stall_cnt", sc1, m_sc[0]);
    check_eq("ms1.flush_cnt", fc1, m_fc[0]);
    check_eq("ms3.stall_cnt", sc3, m_sc[1]);
    check_eq("ms3.flush_cnt", fc3, m_fc[1]);
`endif
  endtask

  task automatic advance();
    model_adv(0);
    model_adv(1);
    @(posedge Clock);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input bit ua, input bit ub, input logic [4:0] dst, input bit rw,
                        input bit ld, input bit br, input bit tk, input bit busy);
    ID_Valid = v; Rs_ID = rs; Rt_ID = rt; Use_Rs_ID = ua; Use_Rt_ID = ub;
    Dest_ID = dst; RegWrite_ID = rw; MemRead_ID = ld;
    Is_Branch_ID = br; Branch_Taken_ID = tk; Mem_Busy = busy;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nop();
    Reset_n = 1'b0;
    model_clear();
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  // Counts consecutive stall cycles on one instance, bounded.
  task automatic count_stalls(input int i, output int unsigned n);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (!(i == 0 ? spc1 : spc3)) return;
      n++;
      advance();
    end
    check_eq("stall_bound", n, 0);
  endtask

  int unsigned stalls;

  initial begin
    ms[0] = 1; ms[1] = 3;
    do_reset();
    sample();
    check_eq("reset.fwd_a3", 32'(fa3), 0);

    // lw $8 ; add $9,$8,$8  (MEM_STAGES=1 view)
    set_in(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0);
    count_stalls(0, stalls);
    check_eq("lu1.stall_len", stalls, 1);
    advance();
    nop(); sample();
    check_eq("lu1.fwd_a", 32'(fa1), 2);
    check_eq("lu1.fwd_b", 32'(fb1), 2);
    advance();

    // add $8 ; sub $10,$8,$3
    do_reset();
    set_in(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0); sample(); advance();
    set_in(1, 8, 3, 1, 1, 10, 1, 0, 0, 0, 0); sample();
    check_eq("alu.no_stall", 32'(spc1), 0);
    advance();
    nop(); sample();
    check_eq("alu.fwd_a", 32'(fa1), 1);
    check_eq("alu.fwd_b", 32'(fb1), 0);
    advance();

    // lw $5 ; or $6,$5,$7  (MEM_STAGES=3 view)
    do_reset();
    set_in(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    count_stalls(1, stalls);
    check_eq("lu3.stall_len", stalls, 3);
    advance();
    nop(); sample();
    check_eq("lu3.fwd_a", 32'(fa3), 4);
    advance();

    // add $4 ; beq $4,$0 taken
    do_reset();
    set_in(1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 0); sample(); advance();
    set_in(1, 4, 0, 1, 1, 0, 0, 0, 1, 1, 0);
    count_stalls(0, stalls);
    check_eq("br.stall_len", stalls, 2);
    check_eq("br.flush", 32'(fl1), 1);
    advance();
    nop(); sample();
    check_eq("br.flush_once", 32'(fl1), 0);
    advance();

    // writer of $0 never causes a stall
    do_reset();
    set_in(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 0, 0, 1, 1, 9, 1, 0, 1, 0, 0); sample();
    check_eq("zero.no_stall1", 32'(spc1), 0);
    check_eq("zero.no_stall3", 32'(spc3), 0);
    advance();

    // Mem_Busy during a load-use stall (MEM_STAGES=3)
    do_reset();
    set_in(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0); sample(); advance();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1); sample();
      check_eq("busy.freeze", 32'(frz3), 1);
      check_eq("busy.no_bubble", 32'(bub3), 0);
      advance();
    end
    set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    count_stalls(1, stalls);
    check_eq("busy.remaining", stalls, 2);
    advance();
    nop(); sample();
    check_eq("busy.fwd_a", 32'(fa3), 4);
    advance();

    // asynchronous reset in the middle of a stall
    do_reset();
    set_in(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0); sample(); advance();
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check_eq("arst.stall3", 32'(spc3), 0);
    check_eq("arst.bubble3", 32'(bub3), 0);
    model_clear();
    #1;
    Reset_n = 1'b1;
    advance();
`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    sample();
    check_eq("cnt.zero", sc3, 0);
    set_in(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); sample(); advance();
    set_in(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    sample(); advance();
    sample(); advance();
    sample();
    check_eq("cnt.two", sc3, 2);
    advance();
`endif

    // randomized traffic with occasional mid-cycle reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 9) < 8, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);
      sample();
      if ($urandom_range(0, 199) == 0) begin
        Reset_n = 1'b0;
        #1;
        model_clear();
        check_eq("rnd.arst_stall", 32'(spc1), 32'(Mem_Busy));
        check_eq("rnd.arst_fwd", 32'(fa3), 0);
        #1;
        Reset_n = 1'b1;
      end
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
